// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared types, defaults and address helper for the gpr_sb register file
//
// Purpose : default widths, data/address typedefs, and addr_valid() which
//           decides whether an address names a real, writable register.
// Ports   : none (package).
package gpr_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
  typedef logic [GPR_DATA_W-1:0] gpr_data_t;

  // An address is usable when it lies inside the array and is not the
  // hardwired zero register.
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned depth,
                                      input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// rtl/gpr_scoreboard.sv - per-register busy bits with set/clear and two lookup ports
//
// Purpose : DEPTH-bit busy vector. Set marks an in-flight producer, clear
//           retires it; set wins when both target the same register.
// Ports   : clk, rst          clock, asynchronous active-high reset
//           set_en_i/addr_i   reserve request (already qualified by caller)
//           clr_en_i/addr_i   write-back clear (already qualified by caller)
//           addr_a_i/addr_b_i lookup addresses
//           busy_a_o/busy_b_o busy bits for the lookups (0 for addresses >= DEPTH)
module gpr_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clear first, then set, so a same-cycle reserve overrides the write-back.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_en_i && (clr_addr_i == ADDR_W'(i))) busy_d[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (set_en_i && (set_addr_i == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    busy_a_o = 1'b0;
    busy_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_a_i == ADDR_W'(i)) busy_a_o = busy_q[i];
      if (addr_b_i == ADDR_W'(i)) busy_b_o = busy_q[i];
    end
  end

endmodule

// File: rtl/gpr_sb.sv
// rtl/gpr_sb.sv - general-purpose register file with busy scoreboard
//
// Purpose : two combinational read ports (A, B), one synchronous write port
//           (C), optional hardwired-zero register 0 and a per-register busy
//           scoreboard. Define GPR_BYPASS_EN to forward the write port to
//           same-address reads within the write cycle.
// Ports   : clk, rst                        clock, asynchronous active-high reset
//           write_enable/addrC/data_in_C    write port C
//           addrA/addrB -> data_out_A/B     read ports
//           reserve_en/reserve_addr         mark a register busy
//           busy_A/busy_B                   scoreboard bits for addrA/addrB
module gpr_sb
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] addrC,
  input  logic [DATA_W-1:0] data_in_C,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  output logic [DATA_W-1:0] data_out_A,
  output logic [DATA_W-1:0] data_out_B,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              busy_A,
  output logic              busy_B
);

  localparam logic ZR = (ZERO_REG != 0);

  logic wr_valid, rsv_valid, a_valid, b_valid;
  assign wr_valid  = write_enable && addr_valid(32'(addrC), DEPTH, ZR);
  assign rsv_valid = reserve_en   && addr_valid(32'(reserve_addr), DEPTH, ZR);
  assign a_valid   = addr_valid(32'(addrA), DEPTH, ZR);
  assign b_valid   = addr_valid(32'(addrB), DEPTH, ZR);

  logic [DATA_W-1:0] regs_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addrC == ADDR_W'(i)) regs_q[i] <= data_in_C;
      end
    end
  end

  logic [DATA_W-1:0] arr_a, arr_b;

  always_comb begin
    arr_a = '0;
    arr_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addrA == ADDR_W'(i)) arr_a = regs_q[i];
      if (addrB == ADDR_W'(i)) arr_b = regs_q[i];
    end
  end

  logic sb_a, sb_b;

  gpr_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (rsv_valid),
    .set_addr_i (reserve_addr),
    .clr_en_i   (wr_valid),
    .clr_addr_i (addrC),
    .addr_a_i   (addrA),
    .addr_b_i   (addrB),
    .busy_a_o   (sb_a),
    .busy_b_o   (sb_b)
  );

`ifdef GPR_BYPASS_EN
  // A read hitting the in-flight write sees the new data now; its producer is
  // retiring this cycle, so it is only busy if re-reserved in the same cycle.
  logic byp_a, byp_b;
  assign byp_a = wr_valid && (addrC == addrA);
  assign byp_b = wr_valid && (addrC == addrB);

  assign data_out_A = byp_a ? data_in_C : (a_valid ? arr_a : '0);
  assign data_out_B = byp_b ? data_in_C : (b_valid ? arr_b : '0);
  assign busy_A     = byp_a ? (rsv_valid && (reserve_addr == addrA)) : (a_valid && sb_a);
  assign busy_B     = byp_b ? (rsv_valid && (reserve_addr == addrB)) : (b_valid && sb_b);
`else
  assign data_out_A = a_valid ? arr_a : '0;
  assign data_out_B = b_valid ? arr_b : '0;
  assign busy_A     = a_valid && sb_a;
  assign busy_B     = b_valid && sb_b;
`endif

endmodule

// File: tb/tb_gpr_sb.sv
// tb/tb_gpr_sb.sv - self-checking bench for gpr_sb against a behavioural model
module tb_gpr_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              write_enable = 1'b0;
  logic [ADDR_W-1:0] addrC = '0;
  logic [DATA_W-1:0] data_in_C = '0;
  logic [ADDR_W-1:0] addrA = '0;
  logic [ADDR_W-1:0] addrB = '0;
  logic [DATA_W-1:0] data_out_A, data_out_B;
  logic              reserve_en = 1'b0;
  logic [ADDR_W-1:0] reserve_addr = '0;
  logic              busy_A, busy_B;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DATA_W-1:0] m_reg  [32];
  bit                m_busy [32];

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  gpr_sb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ZERO_REG (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .addrC        (addrC),
    .data_in_C    (data_in_C),
    .addrA        (addrA),
    .addrB        (addrB),
    .data_out_A   (data_out_A),
    .data_out_B   (data_out_B),
    .reserve_en   (reserve_en),
    .reserve_addr (reserve_addr),
    .busy_A       (busy_A),
    .busy_B       (busy_B)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic bit valid(input int a);
    return (a < DEPTH) && (a != 0);
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (!valid(a)) return '0;
    if (BYP && write_enable && (int'(addrC) == a)) return data_in_C;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!valid(a)) return 1'b0;
    if (BYP && write_enable && (int'(addrC) == a))
      return reserve_en && (int'(reserve_addr) == a);
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance one edge; the model applies write then reserve, so reserve wins.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (write_enable && valid(int'(addrC))) begin
        m_reg[addrC]  = data_in_C;
        m_busy[addrC] = 1'b0;
      end
      if (reserve_en && valid(int'(reserve_addr))) m_busy[reserve_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    reserve_en   = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    addrA = 5'd5;
    @(posedge clk); #1;
    total_cnt++;
    if (data_out_A !== 32'h0 || busy_A !== 1'b0)
      $display("FAIL reset_state: data_out_A=%h busy_A=%b required 0/0", data_out_A, busy_A);
    else pass_cnt++;
    rst = 1'b0;
    write_enable = 1'b1; addrC = 5'd5; data_in_C = 32'hAAAAAAAA;
    reserve_en = 1'b1; reserve_addr = 5'd5;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_out_A !== 32'hAAAAAAAA || busy_A !== 1'b1)
      $display("FAIL reset_prewrite: data_out_A=%h busy_A=%b required aaaaaaaa/1", data_out_A, busy_A);
    else pass_cnt++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (data_out_A !== 32'h0 || busy_A !== 1'b0)
      $display("FAIL reset_async: data_out_A=%h busy_A=%b required 0/0", data_out_A, busy_A);
    else pass_cnt++;
    // Write and reserve held across an edge while in reset are discarded.
    write_enable = 1'b1; addrC = 5'd6; data_in_C = 32'h55555555;
    reserve_en = 1'b1; reserve_addr = 5'd6;
    step();
    rst = 1'b0;
    idle();
    addrA = 5'd6;
    #1;
    total_cnt++;
    if (data_out_A !== 32'h0 || busy_A !== 1'b0)
      $display("FAIL reset_discard: data_out_A=%h busy_A=%b required 0/0", data_out_A, busy_A);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    write_enable = 1'b1; addrC = 5'd5; data_in_C = 32'hAAAAAAAA;
    step();
    addrA = 5'd5;
    addrC = 5'd15; data_in_C = 32'hFFFEAAAA;
    #1;
    total_cnt++;
    if (data_out_A !== 32'hAAAAAAAA)
      $display("FAIL write_read_r5: data_out_A=%h required aaaaaaaa", data_out_A);
    else pass_cnt++;
    step();
    idle();
    addrB = 5'd15;
    #1;
    total_cnt++;
    if (data_out_A !== 32'hAAAAAAAA || data_out_B !== 32'hFFFEAAAA)
      $display("FAIL write_read_both: A=%h B=%h required aaaaaaaa/fffeaaaa", data_out_A, data_out_B);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    write_enable = 1'b1; addrC = 5'd0; data_in_C = 32'h12345678;
    reserve_en = 1'b1; reserve_addr = 5'd0;
    addrA = 5'd0;
    #1;
    total_cnt++;
    if (data_out_A !== 32'h0 || busy_A !== 1'b0)
      $display("FAIL zero_reg_pre: data_out_A=%h busy_A=%b required 0/0", data_out_A, busy_A);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_out_A !== 32'h0 || busy_A !== 1'b0)
      $display("FAIL zero_reg_post: data_out_A=%h busy_A=%b required 0/0", data_out_A, busy_A);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    reserve_en = 1'b1; reserve_addr = 5'd7; addrA = 5'd7;
    step();
    idle();
    #1;
    total_cnt++;
    if (busy_A !== 1'b1)
      $display("FAIL sb_reserve: busy_A=%b required 1", busy_A);
    else pass_cnt++;
    write_enable = 1'b1; addrC = 5'd7; data_in_C = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (busy_A !== (BYP ? 1'b0 : 1'b1) || data_out_A !== (BYP ? 32'hDEADBEEF : 32'h0))
      $display("FAIL sb_write_pre: busy_A=%b data=%h required %b/%h", busy_A, data_out_A,
               BYP ? 1'b0 : 1'b1, BYP ? 32'hDEADBEEF : 32'h0);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (busy_A !== 1'b0 || data_out_A !== 32'hDEADBEEF)
      $display("FAIL sb_write_post: busy_A=%b data=%h required 0/deadbeef", busy_A, data_out_A);
    else pass_cnt++;
    write_enable = 1'b1; addrC = 5'd7; data_in_C = 32'h11112222;
    reserve_en = 1'b1; reserve_addr = 5'd7;
    #1;
    total_cnt++;
    if (busy_A !== (BYP ? 1'b1 : 1'b0))
      $display("FAIL sb_both_pre: busy_A=%b required %b", busy_A, BYP ? 1'b1 : 1'b0);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (busy_A !== 1'b1 || data_out_A !== 32'h11112222)
      $display("FAIL sb_both_post: busy_A=%b data=%h required 1/11112222", busy_A, data_out_A);
    else pass_cnt++;
    // Re-reserve keeps busy set; a single write clears it.
    reserve_en = 1'b1; reserve_addr = 5'd7;
    step();
    idle();
    write_enable = 1'b1; addrC = 5'd7; data_in_C = 32'h33334444;
    step();
    idle();
    #1;
    total_cnt++;
    if (busy_A !== 1'b0)
      $display("FAIL sb_rereserve: busy_A=%b required 0", busy_A);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    addrA = 5'd9;
    write_enable = 1'b1; addrC = 5'd9; data_in_C = 32'hCAFEF00D;
    #1;
    total_cnt++;
    if (data_out_A !== (BYP ? 32'hCAFEF00D : 32'h0))
      $display("FAIL bypass_pre: data_out_A=%h required %h", data_out_A, BYP ? 32'hCAFEF00D : 32'h0);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_out_A !== 32'hCAFEF00D)
      $display("FAIL bypass_post: data_out_A=%h required cafef00d", data_out_A);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    write_enable = 1'b1; addrC = 5'd25; data_in_C = 32'h0BADF00D;
    reserve_en = 1'b1; reserve_addr = 5'd25;
    addrA = 5'd25; addrB = 5'd20;
    #1;
    total_cnt++;
    if (data_out_A !== 32'h0 || busy_A !== 1'b0)
      $display("FAIL oor_pre: data=%h busy=%b required 0/0", data_out_A, busy_A);
    else pass_cnt++;
    step();
    addrC = 5'd19; data_in_C = 32'h19191919; reserve_addr = 5'd19;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_out_A !== 32'h0 || busy_A !== 1'b0 || data_out_B !== 32'h0 || busy_B !== 1'b0)
      $display("FAIL oor_post: A=%h/%b B=%h/%b required 0/0 0/0", data_out_A, busy_A, data_out_B, busy_B);
    else pass_cnt++;
    addrB = 5'd19;
    #1;
    total_cnt++;
    if (data_out_B !== 32'h19191919 || busy_B !== 1'b1)
      $display("FAIL oor_last_reg: B=%h/%b required 19191919/1", data_out_B, busy_B);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      write_enable = 1'($urandom_range(0, 1));
      reserve_en   = 1'($urandom_range(0, 2) == 0);
      addrC        = ADDR_W'($urandom_range(0, 23));
      reserve_addr = ($urandom_range(0, 3) == 0) ? addrC : ADDR_W'($urandom_range(0, 23));
      data_in_C    = $urandom;
      addrA        = ($urandom_range(0, 2) == 0) ? addrC : ADDR_W'($urandom_range(0, 31));
      addrB        = ADDR_W'($urandom_range(0, 23));
      #1;
      total_cnt++;
      if (data_out_A !== exp_data(int'(addrA)) || data_out_B !== exp_data(int'(addrB)) ||
          busy_A !== exp_busy(int'(addrA)) || busy_B !== exp_busy(int'(addrB))) begin
        if (errs < 10)
          $display("FAIL random[%0d]: A@%0d=%h/%b B@%0d=%h/%b required %h/%b %h/%b", n,
                   addrA, data_out_A, busy_A, addrB, data_out_B, busy_B,
                   exp_data(int'(addrA)), exp_busy(int'(addrA)),
                   exp_data(int'(addrB)), exp_busy(int'(addrB)));
        errs++;
      end else pass_cnt++;
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
